// File: rtl/bitwise_pkg.sv
// Shared types and constants for the bitwise shift/load register scheduler.
package bitwise_pkg;

  localparam int DEF_WIDTH = 8;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_SHIFT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

endpackage

// File: rtl/bitwise_sched_if.sv
// Two-requester command bus: producers drive the master side, the scheduler the slave side.
interface bitwise_sched_if
  import bitwise_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CW    = $clog2(WIDTH + 1)
);

  logic [1:0]         req_valid;
  logic [1:0]         req_op;
  logic [2*WIDTH-1:0] req_data;
  logic [2*CW-1:0]    req_cnt;
  logic [1:0]         req_ready;

  modport master (
    output req_valid, req_op, req_data, req_cnt,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_op, req_data, req_cnt,
    output req_ready
  );

endinterface

// File: rtl/bitwise_rr_arb.sv
// Two-way round-robin arbiter: on a tie, the requester that did not win last time is granted.
module bitwise_rr_arb (
  input  logic [1:0] valid,
  input  logic       last,
  input  logic       enable,
  output logic [1:0] grant
);

  always_comb begin
    // NOTE: default assignment first so no path through this block leaves grant unassigned (no latch).
    grant = 2'b00;
    if (enable) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/bitwise_sched.sv
// Scheduler that arbitrates LOAD/SHIFT commands and sequences the bitwise register pins.
// Define BITWISE_SCHED_FORMAL_EN to elaborate the protocol assertions and covers.
module bitwise_sched
  import bitwise_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  bitwise_sched_if.slave   req,
  input  logic             hold,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic             sr_load_en,
  output logic [WIDTH-1:0] sr_load,
  output logic             sr_d,
  output logic             sr_en
);

  localparam logic [1:0]    IDLE  = ST_IDLE;
  localparam logic [1:0]    LOAD  = ST_LOAD;
  localparam logic [1:0]    SHIFT = ST_SHIFT;
  localparam logic [CW-1:0] K_MAX = CW'(WIDTH);

  logic [1:0]       state;
  logic             rr_last;
  logic             id_q;
  logic [WIDTH-1:0] sh_q;
  logic [CW-1:0]    k_q;
  logic [CW-1:0]    idx_q;

  logic [1:0]       grant;
  logic             accept;
  logic             sel_id;
  logic             sel_op;
  logic [WIDTH-1:0] sel_data;
  logic [CW-1:0]    sel_cnt;
  logic [CW-1:0]    sel_k;
  logic             shift_fin;

  bitwise_rr_arb u_arb (
    .valid  (req.req_valid),
    .last   (rr_last),
    .enable (state == IDLE),
    .grant  (grant)
  );

  assign req.req_ready = grant;
  assign accept        = |grant;
  assign sel_id        = grant[1];
  assign sel_op        = req.req_op[sel_id];
  assign sel_data      = sel_id ? req.req_data[WIDTH +: WIDTH] : req.req_data[0 +: WIDTH];
  assign sel_cnt       = sel_id ? req.req_cnt[CW +: CW] : req.req_cnt[0 +: CW];
  assign sel_k         = (sel_cnt > K_MAX) ? K_MAX : sel_cnt;

  // A zero-length shift completes immediately; otherwise the last bit completes only when not stalled.
  assign shift_fin = (state == SHIFT) &&
                     ((k_q == '0) || (!hold && (idx_q == k_q - CW'(1))));

  assign busy       = (state != IDLE);
  assign sr_load_en = (state == LOAD);
  assign sr_load    = (state == LOAD) ? sh_q : '0;
  assign sr_en      = (state == SHIFT) && (k_q != '0) && !hold;
  assign sr_d       = (state == SHIFT) && (k_q != '0) && sh_q[WIDTH-1];
  assign done       = (state == LOAD) || shift_fin;
  assign done_id    = done && id_q;

  // NOTE: every register here is small control/datapath state, so all of it is cleared on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      rr_last <= 1'b1;
      id_q    <= 1'b0;
      sh_q    <= '0;
      k_q     <= '0;
      idx_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        IDLE: begin
          if (accept) begin
            id_q    <= sel_id;
            rr_last <= sel_id;
            sh_q    <= sel_data;
            k_q     <= sel_k;
            idx_q   <= '0;
            state   <= (sel_op == OP_LOAD) ? LOAD : SHIFT;
          end
        end
        LOAD: state <= IDLE;
        SHIFT: begin
          if (shift_fin) begin
            state <= IDLE;
          end else if (!hold) begin
            idx_q <= idx_q + CW'(1);
            sh_q  <= {sh_q[WIDTH-2:0], 1'b0};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BITWISE_SCHED_FORMAL_EN
  a_strobe_excl: assert property (@(posedge clk) disable iff (reset)
    !(sr_load_en && sr_en));
  a_ready_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(req.req_ready) && ((state == IDLE) || (req.req_ready == 2'b00)));
  a_done_busy: assert property (@(posedge clk) disable iff (reset)
    done |-> busy);
  a_idx_range: assert property (@(posedge clk) disable iff (reset)
    idx_q <= K_MAX);

  c_load_done: cover property (@(posedge clk) disable iff (reset)
    (state == LOAD) && done);
  c_full_shift: cover property (@(posedge clk) disable iff (reset)
    (state == SHIFT) && (k_q == K_MAX) && done);
  c_alt_grant: cover property (@(posedge clk) disable iff (reset)
    (accept && !sel_id) ##2 (accept && sel_id));
`endif

endmodule

// File: tb/tb_bitwise_sched.sv
// Scoreboard bench for bitwise_sched: driver predicts grants and queues expected commands, monitor checks pins.
module tb_bitwise_sched;
  import bitwise_pkg::*;

  localparam int W  = 8;
  localparam int CW = 4;

  typedef struct {
    bit         op;
    logic [7:0] data;
    logic [3:0] cnt;
  } cmd_t;

  typedef struct {
    bit         id;
    bit         op;
    logic [7:0] data;
    int         k;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         hold;
  logic         busy, done, done_id, sr_load_en, sr_d, sr_en;
  logic [W-1:0] sr_load;

  bitwise_sched_if #(.WIDTH(W), .CW(CW)) bus ();

  bitwise_sched #(.WIDTH(W), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (bus),
    .hold       (hold),
    .busy       (busy),
    .done       (done),
    .done_id    (done_id),
    .sr_load_en (sr_load_en),
    .sr_load    (sr_load),
    .sr_d       (sr_d),
    .sr_en      (sr_en)
  );

  always #5 clk = ~clk;

  int   vectors    = 0;
  int   miscompares = 0;
  cmd_t pend0[$];
  cmd_t pend1[$];
  exp_t sb[$];
  bit   hold_q[$];
  int   hold_pct   = 0;
  bit   model_last = 1'b1;
  bit   mon_active = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] model_grant(input logic [1:0] v);
    if (v == 2'b11) return model_last ? 2'b01 : 2'b10;
    return v;
  endfunction

  function automatic int eff_k(input logic [3:0] cnt);
    return (int'(cnt) > W) ? W : int'(cnt);
  endfunction

  // Drive pending commands each cycle until everything drains (or the cycle budget runs out).
  task automatic pump(input int budget, input bit cut);
    int          n = 0;
    logic [1:0]  eg;
    cmd_t        c;
    exp_t        e;
    bit          stuck;
    while ((pend0.size() != 0 || pend1.size() != 0 || busy || sb.size() != 0 || mon_active)
           && n < budget) begin
      @(negedge clk);
      bus.req_valid = {pend1.size() != 0, pend0.size() != 0};
      if (pend0.size() != 0) begin
        bus.req_op[0]      = pend0[0].op;
        bus.req_data[7:0]  = pend0[0].data;
        bus.req_cnt[3:0]   = pend0[0].cnt;
      end
      if (pend1.size() != 0) begin
        bus.req_op[1]      = pend1[0].op;
        bus.req_data[15:8] = pend1[0].data;
        bus.req_cnt[7:4]   = pend1[0].cnt;
      end
      hold = (hold_q.size() != 0) ? hold_q.pop_front() : ($urandom_range(99) < hold_pct);
      #1;
      if (!busy) begin
        eg = model_grant(bus.req_valid);
        check("grant", bus.req_ready, eg);
        if (eg != 2'b00) begin
          c = eg[1] ? pend1.pop_front() : pend0.pop_front();
          e.id = eg[1]; e.op = c.op; e.data = c.data; e.k = eff_k(c.cnt);
          sb.push_back(e);
          model_last = eg[1];
        end
      end else begin
        check("ready_while_busy", bus.req_ready, 2'b00);
      end
      n++;
    end
    stuck = !cut && (n >= budget);
    if (!cut) check("drained_within_budget", stuck, 0);
    bus.req_valid = 2'b00;
  endtask

  // Monitor: samples mid-cycle and follows each expected command through its pin sequence.
  initial begin : monitor
    exp_t cur;
    int   prog = 0;
    bit   want_idle = 1'b0;
    bit   exp_bit;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sr", {sr_load_en, sr_en, sr_d, sr_load}, 0);
        sb.delete();
        mon_active = 1'b0;
        want_idle  = 1'b0;
        continue;
      end
      check("strobe_excl", sr_load_en & sr_en, 0);
      if (want_idle) begin
        check("idle_after_done", busy, 0);
        want_idle = 1'b0;
      end
      if (!mon_active && busy) begin
        if (sb.size() == 0) check("unexpected_busy", busy, 0);
        else begin
          cur = sb.pop_front();
          mon_active = 1'b1;
          prog = 0;
        end
      end
      if (!mon_active) begin
        check("idle_quiet", {done, sr_load_en, sr_en, sr_d, sr_load}, 0);
      end else if (cur.op == OP_LOAD) begin
        check("load_en", sr_load_en, 1);
        check("load_data", sr_load, cur.data);
        check("load_done", {done, done_id}, {1'b1, cur.id});
        check("load_no_shift", {sr_en, sr_d}, 0);
        mon_active = 1'b0;
        want_idle  = 1'b1;
      end else if (cur.k == 0) begin
        check("k0_pins", {sr_load_en, sr_en, sr_d, sr_load}, 0);
        check("k0_done", {done, done_id}, {1'b1, cur.id});
        mon_active = 1'b0;
        want_idle  = 1'b1;
      end else begin
        exp_bit = cur.data[W-1-prog];
        check("shift_en", sr_en, !hold);
        check("shift_d", sr_d, exp_bit);
        check("shift_no_load", {sr_load_en, sr_load}, 0);
        if (!hold && prog == cur.k - 1) begin
          check("shift_done", {done, done_id}, {1'b1, cur.id});
          mon_active = 1'b0;
          want_idle  = 1'b1;
        end else begin
          check("shift_not_done", done, 0);
          if (!hold) prog++;
        end
      end
    end
  end

  function automatic cmd_t mk(input bit op, input logic [7:0] data, input logic [3:0] cnt);
    cmd_t c;
    c.op = op; c.data = data; c.cnt = cnt;
    return c;
  endfunction

  initial begin
    reset         = 1'b1;
    hold          = 1'b0;
    bus.req_valid = 2'b00;
    bus.req_op    = 2'b00;
    bus.req_data  = '0;
    bus.req_cnt   = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("ready_none_valid", bus.req_ready, 2'b00);
    check("post_reset_busy", busy, 0);

    // LOAD on requester 0, then a 4-bit SHIFT on requester 1.
    pend0.push_back(mk(OP_LOAD, 8'hA5, 4'd0));
    pump(20, 0);
    pend1.push_back(mk(OP_SHIFT, 8'b1011_0000, 4'd4));
    pump(20, 0);

    // Both requesters hold LOADs: grants must alternate.
    for (int i = 0; i < 3; i++) begin
      pend0.push_back(mk(OP_LOAD, 8'(8'h10 + i), 4'd0));
      pend1.push_back(mk(OP_LOAD, 8'(8'h20 + i), 4'd0));
    end
    pump(40, 0);

    // SHIFT of 3 with a stall on its second cycle.
    hold_q = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    pend0.push_back(mk(OP_SHIFT, 8'b0110_1100, 4'd3));
    pump(20, 0);

    // Zero-length and saturated shifts.
    pend1.push_back(mk(OP_SHIFT, 8'hFF, 4'd0));
    pend0.push_back(mk(OP_SHIFT, 8'h5C, 4'd15));
    pump(40, 0);

    // Reset during the third shift cycle aborts the command.
    hold_q.delete();
    hold_pct = 0;
    pend0.push_back(mk(OP_SHIFT, 8'hC3, 4'd8));
    pump(4, 1);
    #2;
    reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sr", {sr_load_en, sr_en, sr_d, sr_load}, 0);
    pend0.delete();
    pend1.delete();
    model_last = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    pend0.push_back(mk(OP_LOAD, 8'h3C, 4'd0));
    pend1.push_back(mk(OP_LOAD, 8'hC3, 4'd0));
    pump(20, 0);

    // Randomized traffic with random stalls.
    hold_pct = 30;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(1) == 0)
        pend0.push_back(mk(1'($urandom_range(1)), 8'($urandom), 4'($urandom_range(15))));
      else
        pend1.push_back(mk(1'($urandom_range(1)), 8'($urandom), 4'($urandom_range(15))));
    end
    pump(3000, 0);
    hold = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
